// File: rtl/serial_word_collector_if.sv
// Output word port of serial_word_collector: valid/ready handshake carrying
// one assembled WIDTH-bit word.
//   out_data  : assembled word, stable while out_valid=1
//   out_valid : out_data holds an unconsumed word
//   out_ready : consumer accepts; transfer when out_valid & out_ready
// master = word producer (the collector), slave = word consumer.
interface serial_word_collector_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/serial_word_collector.sv
// serial_word_collector
// Gathers the serial bit stream of the upstream shift register into WIDTH-bit
// words and presents each word through a one-word holding register on a
// valid/ready port. A completed word arriving while the holding register is
// full and not being drained is dropped and sets the sticky overflow flag.
//
// Optional feature macro: SWC_PARITY_EN
//   When defined, every word is followed by one even-parity bit; the word
//   completes on that bit and parity_err_o is loaded alongside out_data.
//   When undefined, words complete on data bit WIDTH and parity_err_o is 0.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   bit_en_i     : bit_in_i is valid this cycle
//   bit_in_i     : serial data bit
//   msb_first_i  : 1 = first received bit is the word MSB, 0 = LSB
//   clear_i      : abort the partial word (wins over bit_en_i)
//   out_if       : word output port (out_data / out_valid / out_ready)
//   overflow_o   : sticky, a completed word was dropped; cleared only by rst
//   bit_count_o  : bits of the current word received so far
//   parity_err_o : parity error flag, valid with out_data
module serial_word_collector #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bit_en_i,
  input  logic                        bit_in_i,
  input  logic                        msb_first_i,
  input  logic                        clear_i,
  serial_word_collector_if.master     out_if,
  output logic                        overflow_o,
  output logic [$clog2(WIDTH+2)-1:0]  bit_count_o,
  output logic                        parity_err_o
);

  localparam int CW = $clog2(WIDTH+2);

`ifdef SWC_PARITY_EN
  typedef enum logic {COLLECT, PARITY} state_e;
`else
  typedef enum logic {COLLECT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bitCount_q, bitCount_d;
  logic             msbFirst_q, msbFirst_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic             overflow_q, overflow_d;
`ifdef SWC_PARITY_EN
  logic             parityErr_q, parityErr_d;
  logic             completePar;
`endif

  logic             msbEff;
  logic [WIDTH-1:0] srShift;
  logic             completeNow;
  logic [WIDTH-1:0] completeWord;

  // State register: all state is cleared synchronously by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      sr_q        <= '0;
      bitCount_q  <= '0;
      msbFirst_q  <= 1'b0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SWC_PARITY_EN
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bitCount_q  <= bitCount_d;
      msbFirst_q  <= msbFirst_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      overflow_q  <= overflow_d;
`ifdef SWC_PARITY_EN
      parityErr_q <= parityErr_d;
`endif
    end
  end

  // Next-state logic: bit collection, word completion and output handshake.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bitCount_d   = bitCount_q;
    msbFirst_d   = msbFirst_q;
    outData_d    = outData_q;
    outValid_d   = outValid_q;
    overflow_d   = overflow_q;
    completeNow  = 1'b0;
    completeWord = sr_q;
`ifdef SWC_PARITY_EN
    parityErr_d  = parityErr_q;
    completePar  = 1'b0;
`endif

    // The bit order is sampled on the first bit and held for the whole word.
    msbEff  = (bitCount_q == '0) ? msb_first_i : msbFirst_q;
    srShift = msbEff ? {sr_q[WIDTH-2:0], bit_in_i} : {bit_in_i, sr_q[WIDTH-1:1]};

    // A consumed word frees the holding register; a completion below may refill it.
    if (outValid_q && out_if.out_ready) begin
      outValid_d = 1'b0;
    end

    if (clear_i) begin
      bitCount_d = '0;
      state_d    = COLLECT;
    end else if (bit_en_i) begin
      case (state_q)
        COLLECT: begin
          sr_d = srShift;
          if (bitCount_q == '0) begin
            msbFirst_d = msb_first_i;
          end
          if (bitCount_q == CW'(WIDTH-1)) begin
`ifdef SWC_PARITY_EN
            state_d    = PARITY;
            bitCount_d = CW'(WIDTH);
`else
            completeNow  = 1'b1;
            completeWord = srShift;
            bitCount_d   = '0;
`endif
          end else begin
            bitCount_d = bitCount_q + CW'(1);
          end
        end
`ifdef SWC_PARITY_EN
        PARITY: begin
          // Even parity: data bits plus parity bit must XOR to 0.
          completeNow  = 1'b1;
          completeWord = sr_q;
          completePar  = (^sr_q) ^ bit_in_i;
          bitCount_d   = '0;
          state_d      = COLLECT;
        end
`endif
        default: begin
          state_d    = COLLECT;
          bitCount_d = '0;
        end
      endcase
    end

    // Load only if the register is empty or being drained this same cycle.
    if (completeNow) begin
      if (!outValid_q || out_if.out_ready) begin
        outData_d  = completeWord;
        outValid_d = 1'b1;
`ifdef SWC_PARITY_EN
        parityErr_d = completePar;
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  assign out_if.out_data  = outData_q;
  assign out_if.out_valid = outValid_q;
  assign overflow_o       = overflow_q;
  assign bit_count_o      = bitCount_q;
`ifdef SWC_PARITY_EN
  assign parity_err_o     = parityErr_q;
`else
  assign parity_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Testbench for serial_word_collector (WIDTH=8), default build or with
// SWC_PARITY_EN defined. A table of whole words is applied in a loop, then
// hand-written sequences cover overflow, reset, clear, gaps and back-to-back.
module tb_serial_word_collector;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       bit_in;
  logic       msb_first;
  logic       clear;
  logic       overflow;
  logic [3:0] bit_count;
  logic       parity_err;

  int vecCount  = 0;
  int missCount = 0;

  serial_word_collector_if #(.WIDTH(WIDTH)) swcIf ();

  serial_word_collector #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_en_i     (bit_en),
    .bit_in_i     (bit_in),
    .msb_first_i  (msb_first),
    .clear_i      (clear),
    .out_if       (swcIf),
    .overflow_o   (overflow),
    .bit_count_o  (bit_count),
    .parity_err_o (parity_err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       msb;
    logic [7:0] tx;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs [5];

  // One clock edge; inputs change and outputs are sampled 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    bit_en = 1'b1;
    bit_in = b;
    step();
    bit_en = 1'b0;
  endtask

  // Sends tx[7] first. flipAfterFirst inverts msb_first after bit one to
  // show the order is latched. readyAtEnd drives out_ready on the last bit.
  task automatic applyStimulus(input logic msb, input logic [7:0] tx,
                               input logic readyAtEnd, input logic flipAfterFirst);
    for (int i = 7; i >= 0; i--) begin
      msb_first = (flipAfterFirst && i != 7) ? ~msb : msb;
`ifndef SWC_PARITY_EN
      if (i == 0) swcIf.out_ready = readyAtEnd;
`endif
      sendBit(tx[i]);
    end
`ifdef SWC_PARITY_EN
    swcIf.out_ready = readyAtEnd;
    sendBit(^tx);
`endif
  endtask

  initial begin
    vecs[0] = '{msb: 1'b1, tx: 8'b1010_0101, expData: 8'hA5};
    vecs[1] = '{msb: 1'b0, tx: 8'b1100_0000, expData: 8'h03};
    vecs[2] = '{msb: 1'b1, tx: 8'b0011_1100, expData: 8'h3C};
    vecs[3] = '{msb: 1'b0, tx: 8'b0101_1010, expData: 8'h5A};
    vecs[4] = '{msb: 1'b0, tx: 8'b1000_0000, expData: 8'h01};

    rst = 1'b1; bit_en = 1'b0; bit_in = 1'b0; msb_first = 1'b1; clear = 1'b0;
    swcIf.out_ready = 1'b0;
    step();
    step();
    checkOutput("reset out_valid", 32'(swcIf.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(swcIf.out_data), 32'h00);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset bit_count", 32'(bit_count), 32'd0);
    checkOutput("reset parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    swcIf.out_ready = 1'b1;
    step();

    // Word table: each word appears for exactly one cycle with out_ready=1.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].msb, vecs[v].tx, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d out_valid", v), 32'(swcIf.out_valid), 32'd1);
      checkOutput($sformatf("vec%0d out_data", v), 32'(swcIf.out_data), 32'(vecs[v].expData));
      checkOutput($sformatf("vec%0d bit_count", v), 32'(bit_count), 32'd0);
      checkOutput($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'd0);
      step();
      checkOutput($sformatf("vec%0d drained", v), 32'(swcIf.out_valid), 32'd0);
    end
    checkOutput("table overflow", 32'(overflow), 32'd0);

    // Bit order latched on the first bit: later msb_first changes ignored.
    applyStimulus(1'b1, 8'b1010_0101, 1'b1, 1'b1);
    checkOutput("latch out_data", 32'(swcIf.out_data), 32'hA5);
    step();

    // Overflow: second word dropped while the first is held.
    swcIf.out_ready = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("ovf first valid", 32'(swcIf.out_valid), 32'd1);
    checkOutput("ovf first data", 32'(swcIf.out_data), 32'h3C);
    checkOutput("ovf not yet", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    checkOutput("ovf kept data", 32'(swcIf.out_data), 32'h3C);
    checkOutput("ovf kept valid", 32'(swcIf.out_valid), 32'd1);
    checkOutput("ovf set", 32'(overflow), 32'd1);

    // Mid-word reset with a pending word: everything returns to reset values.
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    checkOutput("midword bit_count", 32'(bit_count), 32'd4);
    checkOutput("ovf sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rst out_valid", 32'(swcIf.out_valid), 32'd0);
    checkOutput("rst out_data", 32'(swcIf.out_data), 32'h00);
    checkOutput("rst overflow", 32'(overflow), 32'd0);
    checkOutput("rst bit_count", 32'(bit_count), 32'd0);
    rst = 1'b0;
    swcIf.out_ready = 1'b1;

    // Gapped bits, then clear together with bit_en: partial word discarded.
    msb_first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sendBit(1'b1);
      step();
    end
    checkOutput("gapped bit_count", 32'(bit_count), 32'd5);
    clear = 1'b1;
    bit_en = 1'b1;
    bit_in = 1'b1;
    step();
    clear = 1'b0;
    bit_en = 1'b0;
    checkOutput("clear bit_count", 32'(bit_count), 32'd0);
    checkOutput("clear out_valid", 32'(swcIf.out_valid), 32'd0);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    checkOutput("after clear data", 32'(swcIf.out_data), 32'h5A);
    checkOutput("after clear valid", 32'(swcIf.out_valid), 32'd1);
    checkOutput("after clear bit_count", 32'(bit_count), 32'd0);

    // Back-to-back: completion with a held word and out_ready=1 reloads.
    swcIf.out_ready = 1'b0;
    applyStimulus(1'b1, 8'h96, 1'b1, 1'b0);
    checkOutput("b2b data", 32'(swcIf.out_data), 32'h96);
    checkOutput("b2b valid", 32'(swcIf.out_valid), 32'd1);
    checkOutput("b2b overflow", 32'(overflow), 32'd0);
    step();
    checkOutput("b2b drained", 32'(swcIf.out_valid), 32'd0);

`ifdef SWC_PARITY_EN
    // Parity: A5 has even weight, so parity bit 1 is an error and 0 is not.
    msb_first = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hA5;
      sendBit(w[i]);
    end
    checkOutput("par bit_count", 32'(bit_count), 32'd8);
    checkOutput("par not done", 32'(swcIf.out_valid), 32'd0);
    sendBit(1'b1);
    checkOutput("par1 data", 32'(swcIf.out_data), 32'hA5);
    checkOutput("par1 err", 32'(parity_err), 32'd1);
    step();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hA5;
      sendBit(w[i]);
    end
    sendBit(1'b0);
    checkOutput("par0 valid", 32'(swcIf.out_valid), 32'd1);
    checkOutput("par0 err", 32'(parity_err), 32'd0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
